// File: rtl/if_id_stage_reg.sv
// IF->ID pipeline register. Tracks whether the ID slot is empty, showing the
// SRAM read data live (FRESH), or showing a captured copy (HELD). The capture
// exists because the SRAM data is only valid the cycle after the fetch.
module if_id_stage_reg #(
  parameter int                DW        = 32,
  parameter logic [DW-1:0]     NOP_INSTR = '0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] IF_PC,
  input  logic          IF_Valid,
  input  logic          IF_ExcAdEL,
  input  logic          IF_InDelaySlot,
  input  logic [DW-1:0] inst_sram_rdata,
  input  logic          ID_Stall,
  input  logic          ID_Flush,
  output logic [DW-1:0] ID_PC,
  output logic [DW-1:0] ID_Instr,
  output logic          ID_Valid,
  output logic          ID_ExcAdEL,
  output logic          ID_InDelaySlot
);

  typedef enum logic [1:0] {EMPTY, FRESH, HELD} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] hold_instr;

  // Slot state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  // Next state: flush beats stall beats advance
  always_comb begin
    state_d = state_q;
    if (ID_Flush)      state_d = EMPTY;
    else if (ID_Stall) state_d = (state_q == FRESH) ? HELD : state_q;
    else               state_d = IF_Valid ? FRESH : EMPTY;
  end

  // ID side-band registers; the first stalled cycle of a FRESH slot is the
  // only moment the SRAM data is still valid, so it is captured then.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ID_PC          <= '0;
      ID_Valid       <= 1'b0;
      ID_ExcAdEL     <= 1'b0;
      ID_InDelaySlot <= 1'b0;
      hold_instr     <= '0;
    end else if (ID_Flush) begin
      ID_Valid       <= 1'b0;
      ID_ExcAdEL     <= 1'b0;
      ID_InDelaySlot <= 1'b0;
    end else if (ID_Stall) begin
      if (state_q == FRESH) hold_instr <= inst_sram_rdata;
    end else if (IF_Valid) begin
      ID_PC          <= IF_PC;
      ID_Valid       <= 1'b1;
      ID_ExcAdEL     <= IF_ExcAdEL;
      ID_InDelaySlot <= IF_InDelaySlot;
    end else begin
      ID_Valid       <= 1'b0;
    end
  end

  // Instruction mux; a misaligned fetch never reached the SRAM, so its data is junk
  always_comb begin
    ID_Instr = NOP_INSTR;
    if (!ID_ExcAdEL) begin
      case (state_q)
        FRESH:   ID_Instr = inst_sram_rdata;
        HELD:    ID_Instr = hold_instr;
        default: ID_Instr = NOP_INSTR;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Scoreboard bench for if_id_stage_reg: a slot-level model predicts what ID
// should show each cycle, a monitor compares at the falling edge.
module tb_if_id_stage_reg;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] IF_PC, inst_sram_rdata, ID_PC, ID_Instr;
  logic        IF_Valid, IF_ExcAdEL, IF_InDelaySlot, ID_Stall, ID_Flush;
  logic        ID_Valid, ID_ExcAdEL, ID_InDelaySlot;

  always #5 clk = ~clk;

  if_id_stage_reg #(.DW(32), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .resetn(resetn),
    .IF_PC(IF_PC), .IF_Valid(IF_Valid), .IF_ExcAdEL(IF_ExcAdEL),
    .IF_InDelaySlot(IF_InDelaySlot), .inst_sram_rdata(inst_sram_rdata),
    .ID_Stall(ID_Stall), .ID_Flush(ID_Flush),
    .ID_PC(ID_PC), .ID_Instr(ID_Instr), .ID_Valid(ID_Valid),
    .ID_ExcAdEL(ID_ExcAdEL), .ID_InDelaySlot(ID_InDelaySlot)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic        ds;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Model: the ID slot holds one fetched instruction (or nothing).
  logic        m_valid = 1'b0, m_exc = 1'b0, m_ds = 1'b0;
  logic [31:0] m_pc = '0, m_instr = '0;
  logic        pf_live = 1'b0;   // last cycle issued a real SRAM read
  logic [31:0] pf_data = '0;     // the word that read returns
  logic [31:0] cur_data = '0;    // memory word for the fetch driven now
  logic [31:0] junk = '0;        // bus value when no read is returning

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
    end
  endtask

  // Apply the slot rules for the edge that just happened
  task automatic model_step();
    if (ID_Flush) begin
      m_valid = 1'b0; m_exc = 1'b0; m_ds = 1'b0;
    end else if (ID_Stall) begin
      // slot contents frozen
    end else if (IF_Valid) begin
      m_valid = 1'b1; m_pc = IF_PC; m_exc = IF_ExcAdEL;
      m_ds = IF_InDelaySlot; m_instr = cur_data;
    end else begin
      m_valid = 1'b0;
    end
    pf_live = IF_Valid && !IF_ExcAdEL;
    pf_data = cur_data;
  endtask

  task automatic cyc(input logic v, input logic [31:0] pc, input logic exc, input logic ds,
                     input logic [31:0] data, input logic st, input logic fl);
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    IF_Valid = v; IF_PC = pc; IF_ExcAdEL = exc; IF_InDelaySlot = ds;
    ID_Stall = st; ID_Flush = fl; cur_data = data;
    inst_sram_rdata = pf_live ? pf_data : junk;
    e.v = m_valid; e.pc = m_pc; e.exc = m_exc; e.ds = m_ds;
    e.instr = (m_valid && !m_exc) ? m_instr : 32'h0;
    q.push_back(e);
  endtask

  // Monitor: one expectation per driven cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_valid", {31'b0, ID_Valid}, {31'b0, e.v});
      chk("sb_instr", ID_Instr, e.instr);
      if (e.v) begin
        chk("sb_pc", ID_PC, e.pc);
        chk("sb_adel", {31'b0, ID_ExcAdEL}, {31'b0, e.exc});
        chk("sb_ds", {31'b0, ID_InDelaySlot}, {31'b0, e.ds});
      end
    end
  end

  initial begin
    resetn = 1'b0;
    IF_PC = '0; IF_Valid = 0; IF_ExcAdEL = 0; IF_InDelaySlot = 0;
    ID_Stall = 0; ID_Flush = 0; inst_sram_rdata = 32'hA5A5A5A5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, ID_Valid}, 32'h0);
    chk("rst_instr", ID_Instr, 32'h0);
    chk("rst_pc", ID_PC, 32'h0);
    resetn = 1'b1;

    // Streaming, then a 3-cycle stall on the second instruction
    cyc(1, 32'hBFC00000, 0, 0, 32'h24080001, 0, 0);
    cyc(1, 32'hBFC00004, 0, 0, 32'h24080002, 0, 0);
    @(negedge clk); chk("stream_pc0", ID_PC, 32'hBFC00000); chk("stream_i0", ID_Instr, 32'h24080001);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'hBFC00008, 0, 0, 32'hDEADBEEF, 1, 0);
      @(negedge clk); chk("stall_instr", ID_Instr, 32'h24080002); chk("stall_pc", ID_PC, 32'hBFC00004);
    end
    cyc(1, 32'hBFC00008, 0, 0, 32'h24080003, 0, 0);
    @(negedge clk); chk("release_instr", ID_Instr, 32'h24080002);
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 0);
    @(negedge clk); chk("adv_pc", ID_PC, 32'hBFC00008); chk("adv_instr", ID_Instr, 32'h24080003);

    // Flush and stall together drop the fetch
    cyc(1, 32'hBFC0000C, 0, 0, 32'h11111111, 1, 1);
    cyc(1, 32'hBFC00010, 0, 0, 32'h24080005, 0, 0);
    @(negedge clk); chk("flush_valid", {31'b0, ID_Valid}, 32'h0); chk("flush_instr", ID_Instr, 32'h0);
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 0);
    @(negedge clk); chk("post_flush_instr", ID_Instr, 32'h24080005);

    // Misaligned fetch: bus carries data but ID must show NOP
    cyc(1, 32'hBFC00002, 1, 0, 32'h12345678, 0, 0);
    junk = 32'h12345678;
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    chk("adel_flag", {31'b0, ID_ExcAdEL}, 32'h1);
    chk("adel_instr", ID_Instr, 32'h0);
    chk("adel_pc", ID_PC, 32'hBFC00002);

    // Delay-slot flag follows its instruction through HELD
    cyc(1, 32'hBFC00014, 0, 1, 32'h00000014, 0, 0);
    cyc(1, 32'hBFC00018, 0, 0, 32'h00000018, 1, 0);
    @(negedge clk); chk("ds_fresh", {31'b0, ID_InDelaySlot}, 32'h1);
    cyc(1, 32'hBFC00018, 0, 0, 32'h00000018, 1, 0);
    @(negedge clk); chk("ds_held", {31'b0, ID_InDelaySlot}, 32'h1);
    cyc(1, 32'hBFC00018, 0, 0, 32'h00000018, 0, 0);
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 0);
    @(negedge clk); chk("ds_next", {31'b0, ID_InDelaySlot}, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      junk = $urandom;
      cyc(($urandom_range(0, 3) != 0), {$urandom} & 32'hFFFFFFFC | {30'b0, 2'(($urandom_range(0, 9) == 0) ? 2 : 0)},
          ($urandom_range(0, 9) == 0), 1'($urandom), $urandom,
          ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0));
    end

    // Reset while HELD clears everything before any edge
    cyc(1, 32'hBFC00100, 0, 0, 32'hCAFEF00D, 0, 0);
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 0);
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 0);
    @(negedge clk);
    chk("held_instr", ID_Instr, 32'hCAFEF00D);
    #2;
    resetn = 1'b0;
    inst_sram_rdata = 32'h77777777;
    #1;
    chk("mid_rst_valid", {31'b0, ID_Valid}, 32'h0);
    chk("mid_rst_instr", ID_Instr, 32'h0);
    chk("mid_rst_pc", ID_PC, 32'h0);
    chk("mid_rst_ds", {31'b0, ID_InDelaySlot}, 32'h0);
    IF_Valid = 0; ID_Stall = 0; ID_Flush = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    m_valid = 0; m_exc = 0; m_ds = 0; m_pc = '0; pf_live = 0;
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 0);
    @(negedge clk); chk("after_rst_instr", ID_Instr, 32'h0);
    cyc(1, 32'hBFC00200, 0, 0, 32'h3C1DA000, 0, 0);
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 0);
    @(negedge clk); chk("after_rst_fetch", ID_Instr, 32'h3C1DA000);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
